// File: rtl/link_pkg.sv
// Shared definitions for the link-cable serial port: SC register layout and
// the transfer state encoding.
package link_pkg;

    localparam int SC_START = 7;
    localparam int SC_FAST  = 1;
    localparam int SC_CLK   = 0;

    localparam logic [7:0] SC_UNUSED_MASK = 8'h7C;
    localparam logic [7:0] SC_RESET       = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } link_state_e;

    // Unimplemented SC bits always read back as ones.
    function automatic logic [7:0] sc_pack(input logic start, input logic fast, input logic clk_int);
        logic [7:0] v;
        v = 8'h00;
        v[SC_START] = start;
        v[SC_FAST]  = fast;
        v[SC_CLK]   = clk_int;
        return v | SC_UNUSED_MASK;
    endfunction

endpackage

// File: rtl/link_sck_gen.sv
// Internal serial-clock divider: toggles o_sck every half period while running
// and flags which edge (fall/rise) the toggle produces.
module link_sck_gen #(
    parameter int HALF_SLOW = 252,
    parameter int HALF_FAST = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_fast,
    output logic o_fall,
    output logic o_rise,
    output logic o_sck
);

    localparam int HMAX  = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
    localparam int CNT_W = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(HALF_FAST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_tick;

    assign w_tick = !i_clear && (r_cnt == (i_fast ? LAST_FAST : LAST_SLOW));
    assign o_fall = w_tick && r_sck;
    assign o_rise = w_tick && !r_sck;
    assign o_sck  = r_sck;

    // Idle level is high, so a restarted transfer always begins with a fall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load || i_clear) begin
            r_cnt <= '0;
            r_sck <= 1'b1;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/link_tristate.sv
// Bus driver for the CPU data bus; releases the bus to high-Z unless enabled.
module link_tristate #(
    parameter int W = 8
) (
    input  logic         i_oe,
    input  logic [W-1:0] i_data,
    inout  wire  [W-1:0] io_pad
);

    assign io_pad = i_oe ? i_data : {W{1'bz}};

endmodule

// File: rtl/link_serial_port.sv
// Memory-mapped SB/SC link-cable serial port with master/slave clocking,
// selectable bit rate and an optional slave stall watchdog.
module link_serial_port
    import link_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DIV_SLOW      = 252,
    parameter int DIV_FAST      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STALL_TIMEOUT = 0
) (
    input  logic              cpu_clock,
    input  logic              reset_n,
    inout  wire  [DATA_W-1:0] data_ext,
    input  logic              addr_in_SB,
    input  logic              addr_in_SC,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic              sin,
    input  logic              sck_in,
    output logic              sout,
    output logic              sck_out,
    output logic              sck_oe,
    output logic              link_cable_interrupt,
    output logic              xfer_abort,
    output logic              busy
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
    localparam int WD_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

    link_state_e       r_state;
    logic [DATA_W-1:0] r_sb;
    logic              r_start;
    logic              r_fast;
    logic              r_clk_int;
    logic              r_sout;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              r_irq;
    logic              r_abort;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_wd_armed;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sin_sync;
    logic                   r_sck_prev;

    logic              w_sck_s;
    logic              w_sin_s;
    logic              w_ext_fall;
    logic              w_ext_rise;
    logic              w_gen_fall;
    logic              w_gen_rise;
    logic              w_gen_sck;
    logic              w_gen_run;
    logic              w_fall;
    logic              w_rise;
    logic              w_wr_sb;
    logic              w_wr_sc;
    logic [DATA_W-1:0] w_wdata;
    logic              w_start;
    logic              w_sw_abort;
    logic              w_wd_abort;
    logic [DATA_W-1:0] w_sc_rd;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rd_oe;

    // Both pins cross into cpu_clock through matching chains so data stays
    // aligned with the clock edge that samples it.
    always_ff @(posedge cpu_clock) begin
        if (!reset_n) begin
            r_sck_sync <= '1;
            r_sin_sync <= '1;
            r_sck_prev <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
            r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], sin};
            r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_sin_s    = r_sin_sync[SYNC_STAGES-1];
    assign w_ext_fall = r_sck_prev && !w_sck_s;
    assign w_ext_rise = !r_sck_prev && w_sck_s;

    assign w_gen_run = (r_state == ST_SHIFT) && r_clk_int;

    link_sck_gen #(
        .HALF_SLOW (DIV_SLOW),
        .HALF_FAST (DIV_FAST)
    ) u_sck_gen (
        .i_clk   (cpu_clock),
        .i_rst_n (reset_n),
        .i_load  (w_start),
        .i_clear (!w_gen_run),
        .i_fast  (r_fast),
        .o_fall  (w_gen_fall),
        .o_rise  (w_gen_rise),
        .o_sck   (w_gen_sck)
    );

    assign w_fall = (r_state == ST_SHIFT) && (r_clk_int ? w_gen_fall : w_ext_fall);
    assign w_rise = (r_state == ST_SHIFT) && (r_clk_int ? w_gen_rise : w_ext_rise);

    assign w_wdata    = data_ext;
    assign w_wr_sb    = mem_we && addr_in_SB;
    assign w_wr_sc    = mem_we && addr_in_SC;
    // DONE accepts a start so a back-to-back transfer loses no cycle.
    assign w_start    = w_wr_sc && w_wdata[SC_START] && (r_state != ST_SHIFT);
    assign w_sw_abort = w_wr_sc && !w_wdata[SC_START];
    assign w_wd_abort = (STALL_TIMEOUT > 0) && !r_clk_int && r_wd_armed &&
                        !(w_ext_fall || w_ext_rise) &&
                        (int'(r_wd_cnt) == STALL_TIMEOUT - 1);

    always_ff @(posedge cpu_clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sb       <= '0;
            r_start    <= SC_RESET[SC_START];
            r_fast     <= SC_RESET[SC_FAST];
            r_clk_int  <= SC_RESET[SC_CLK];
            r_sout     <= 1'b1;
            r_bit_cnt  <= '0;
            r_irq      <= 1'b0;
            r_abort    <= 1'b0;
            r_wd_cnt   <= '0;
            r_wd_armed <= 1'b0;
        end else begin
            r_irq   <= 1'b0;
            r_abort <= 1'b0;
            unique case (r_state)
                ST_SHIFT: begin
                    if (w_sw_abort || w_wd_abort) begin
                        r_state <= ST_IDLE;
                        r_start <= 1'b0;
                        r_abort <= 1'b1;
                    end else begin
                        if (w_fall) r_sout <= r_sb[DATA_W-1];
                        if (w_rise) begin
                            r_sb       <= {r_sb[DATA_W-2:0], w_sin_s};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            r_wd_armed <= 1'b1;
                            if (r_bit_cnt == LAST_BIT) r_state <= ST_DONE;
                        end
                        if (w_fall || w_rise)  r_wd_cnt <= '0;
                        else if (r_wd_armed)   r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_state == ST_DONE) begin
                        r_irq   <= 1'b1;
                        r_start <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    if (w_wr_sb && r_state == ST_IDLE) r_sb <= w_wdata;
                    if (w_wr_sc) begin
                        r_fast    <= w_wdata[SC_FAST];
                        r_clk_int <= w_wdata[SC_CLK];
                    end
                    if (w_start) begin
                        r_start    <= 1'b1;
                        r_state    <= ST_SHIFT;
                        r_bit_cnt  <= '0;
                        r_wd_cnt   <= '0;
                        r_wd_armed <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign w_sc_rd = DATA_W'(sc_pack(r_start, r_fast, r_clk_int));
    assign w_rdata = addr_in_SB ? r_sb : w_sc_rd;
    assign w_rd_oe = mem_re && (addr_in_SB || addr_in_SC);

    link_tristate #(
        .W (DATA_W)
    ) u_bus_drv (
        .i_oe   (w_rd_oe),
        .i_data (w_rdata),
        .io_pad (data_ext)
    );

    assign sout                 = r_sout;
    assign sck_out              = w_gen_sck;
    assign sck_oe               = r_start && r_clk_int;
    assign busy                 = r_start;
    assign link_cable_interrupt = r_irq;
    assign xfer_abort           = r_abort;

endmodule
